// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: holds the MAR and runs single read/write RAM accesses
// with a fixed number of wait states, returning read data and a level ready flag.
module mem_bus_ctrl #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              reset_cycle,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic              addr_load,
   input  logic              rd_req,
   input  logic              wr_req,
   input  logic [7:0]        wr_data,
   output logic [7:0]        data_out,
   output logic              bus_ready,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        mem_wdata,
   output logic              mem_re,
   output logic              mem_we
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   logic [1:0]        state_reg;
   logic [ADDR_W-1:0] mar_reg;
   logic [3:0]        wcnt_reg;
   logic              is_wr_reg;
   logic [7:0]        data_out_reg;
   logic [7:0]        wdata_reg;
   logic              ready_reg;
   logic              start;

   // Requests are only taken outside ACCESS; anything arriving mid-access is dropped.
   assign start = (state_reg != ST_ACCESS) && (rd_req || wr_req);

   always_ff @(posedge clk) begin
      if (reset_cycle) begin
         state_reg    <= ST_IDLE;
         mar_reg      <= '0;
         wcnt_reg     <= '0;
         is_wr_reg    <= 1'b0;
         data_out_reg <= '0;
         wdata_reg    <= '0;
         ready_reg    <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (addr_load) begin
                  mar_reg   <= addr_in;
                  ready_reg <= 1'b0;
               end
               if (start) begin
                  state_reg <= ST_ACCESS;
                  wcnt_reg  <= WAIT_INIT;
                  is_wr_reg <= wr_req;
                  ready_reg <= 1'b0;
                  if (wr_req) begin
                     wdata_reg <= wr_data;
                  end
               end
            end
            ST_ACCESS: begin
               if (wcnt_reg != 4'd0) begin
                  wcnt_reg <= wcnt_reg - 4'd1;
               end else begin
                  if (!is_wr_reg) begin
                     data_out_reg <= mem_rdata;
                  end
                  state_reg <= ST_DONE;
                  ready_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // All bus outputs decode from registers only, so requests never reach them combinationally.
   assign busy      = (state_reg == ST_ACCESS);
   assign mem_re    = busy && !is_wr_reg;
   assign mem_we    = busy && is_wr_reg && (wcnt_reg == 4'd0);
   assign mem_addr  = mar_reg;
   assign mem_wdata = wdata_reg;
   assign data_out  = data_out_reg;
   assign bus_ready = ready_reg;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: one instance with 2 wait states, one with none,
// each backed by a behavioural RAM; read/write results checked via scoreboards.
module tb_mem_bus_ctrl;

   localparam int WS = 2;

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
   } txn_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_cycle = 1'b1;
   logic [7:0] addr_in = '0, wr_data = '0;
   logic       addr_load = 1'b0, rd_req = 1'b0, wr_req = 1'b0;
   logic [7:0] data_out, mem_addr, mem_rdata, mem_wdata;
   logic       bus_ready, busy, mem_re, mem_we;

   logic [7:0] z_addr_in = '0, z_wr_data = '0;
   logic       z_addr_load = 1'b0, z_rd_req = 1'b0, z_wr_req = 1'b0;
   logic [7:0] z_data_out, z_mem_addr, z_mem_rdata, z_mem_wdata;
   logic       z_bus_ready, z_busy, z_mem_re, z_mem_we;

   logic [7:0] ram [256];
   logic [7:0] z_ram [256];
   logic       pre_en = 1'b0;
   logic [7:0] pre_addr = '0, pre_data = '0;

   int   errors = 0;
   int   checks = 0;
   txn_t sb[$];
   txn_t zq[$];

   mem_bus_ctrl #(.ADDR_W(8), .WAIT_STATES(WS)) dut (
      .clk(clk), .reset_cycle(reset_cycle), .addr_in(addr_in), .addr_load(addr_load),
      .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data), .data_out(data_out),
      .bus_ready(bus_ready), .busy(busy), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we)
   );

   mem_bus_ctrl #(.ADDR_W(8), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset_cycle(reset_cycle), .addr_in(z_addr_in), .addr_load(z_addr_load),
      .rd_req(z_rd_req), .wr_req(z_wr_req), .wr_data(z_wr_data), .data_out(z_data_out),
      .bus_ready(z_bus_ready), .busy(z_busy), .mem_addr(z_mem_addr), .mem_rdata(z_mem_rdata),
      .mem_wdata(z_mem_wdata), .mem_re(z_mem_re), .mem_we(z_mem_we)
   );

   assign mem_rdata   = ram[mem_addr];
   assign z_mem_rdata = z_ram[z_mem_addr];

   always @(posedge clk) begin
      if (pre_en) begin
         ram[pre_addr]   <= pre_data;
         z_ram[pre_addr] <= pre_data;
      end else begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         if (z_mem_we) z_ram[z_mem_addr] <= z_mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Completion monitor for the main instance: each rising bus_ready retires one scoreboard entry.
   logic prev_ready = 1'b0;
   logic [7:0] last_rd = '0;
   txn_t mon_t;
   always @(negedge clk) begin
      if (bus_ready === 1'b1 && prev_ready == 1'b0) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_done", 1, 0);
         end else begin
            mon_t = sb.pop_front();
            if (!mon_t.wr) begin
               chk("sb_rd_data", data_out, mon_t.data);
               last_rd = mon_t.data;
            end else begin
               chk("sb_wr_ram", ram[mon_t.addr], mon_t.data);
               chk("sb_wr_keeps_dout", data_out, last_rd);
            end
            $display("txn %s addr=%02h data=%02h dout=%02h", mon_t.wr ? "WR" : "RD",
                     mon_t.addr, mon_t.data, data_out);
         end
      end
      prev_ready = (bus_ready === 1'b1);
   end

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      pre_addr = a;
      pre_data = d;
      pre_en   = 1'b1;
      @(posedge clk);
      #1 pre_en = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic [7:0] a, input logic ld, input logic rd, input logic wr,
                        input logic [7:0] wd);
      addr_in   = a;
      addr_load = ld;
      rd_req    = rd;
      wr_req    = wr;
      wr_data   = wd;
      @(posedge clk);
      @(negedge clk);
      addr_load = 1'b0;
      rd_req    = 1'b0;
      wr_req    = 1'b0;
   endtask

   // n counts negedges since the accepting edge; mem_re/mem_we activity is tallied per cycle.
   task automatic wait_done(input logic inject, output int n, output int re, output int we,
                            output int we_at);
      n = 1; re = 0; we = 0; we_at = 0;
      while (bus_ready !== 1'b1 && n < 20) begin
         if (mem_re) re++;
         if (mem_we) begin
            we++;
            we_at = n;
         end
         if (inject && n == 1) begin
            addr_in   = 8'h77;
            addr_load = 1'b1;
            rd_req    = 1'b1;
         end else begin
            addr_load = 1'b0;
            rd_req    = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      addr_load = 1'b0;
      rd_req    = 1'b0;
   endtask

   initial begin
      int n, re, we, wat, seen;
      txn_t t;

      // Reset asserted together with a read request
      rd_req = 1'b1;
      @(negedge clk);
      preload(8'h10, 8'hA5); preload(8'h3F, 8'h00); preload(8'h20, 8'h00);
      preload(8'h40, 8'h11); preload(8'h77, 8'h22); preload(8'h50, 8'h00);
      preload(8'h01, 8'hA1); preload(8'h02, 8'hA2); preload(8'h03, 8'hA3);
      @(negedge clk);
      chk("rst_data_out", data_out, 0);
      chk("rst_bus_ready", bus_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_re", mem_re, 0);
      chk("rst_mem_we", mem_we, 0);
      rd_req = 1'b0;
      reset_cycle = 1'b0;
      @(negedge clk);

      // Read 0x10 with same-cycle address load
      sb.push_back('{1'b0, 8'h10, 8'hA5});
      issue(8'h10, 1'b1, 1'b1, 1'b0, 8'h00);
      chk("rd_mem_addr", mem_addr, 8'h10);
      chk("rd_busy", busy, 1);
      chk("rd_ready_low", bus_ready, 0);
      wait_done(1'b0, n, re, we, wat);
      chk("rd_latency", n, WS + 2);
      chk("rd_re_cycles", re, WS + 1);
      chk("rd_no_we", we, 0);
      repeat (3) @(negedge clk);
      chk("rd_hold_ready", bus_ready, 1);
      chk("rd_hold_data", data_out, 8'hA5);

      // Address load alone from DONE clears ready
      addr_in = 8'h3F;
      addr_load = 1'b1;
      @(posedge clk);
      @(negedge clk);
      addr_load = 1'b0;
      chk("ld_ready_clr", bus_ready, 0);
      chk("ld_mar", mem_addr, 8'h3F);
      chk("ld_not_busy", busy, 0);

      // Write 0x5C to 0x3F, then read it back
      sb.push_back('{1'b1, 8'h3F, 8'h5C});
      issue(8'h00, 1'b0, 1'b0, 1'b1, 8'h5C);
      chk("wr_mem_wdata", mem_wdata, 8'h5C);
      wait_done(1'b0, n, re, we, wat);
      chk("wr_latency", n, WS + 2);
      chk("wr_we_count", we, 1);
      chk("wr_we_last_cycle", wat, WS + 1);
      chk("wr_no_re", re, 0);
      chk("wr_dout_unchanged", data_out, 8'hA5);
      sb.push_back('{1'b0, 8'h3F, 8'h5C});
      issue(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
      wait_done(1'b0, n, re, we, wat);
      chk("rb_latency", n, WS + 2);

      // Read/write collision: write wins
      sb.push_back('{1'b1, 8'h20, 8'h99});
      issue(8'h20, 1'b1, 1'b1, 1'b1, 8'h99);
      wait_done(1'b0, n, re, we, wat);
      chk("col_no_re", re, 0);
      chk("col_we_count", we, 1);
      sb.push_back('{1'b0, 8'h20, 8'h99});
      issue(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
      wait_done(1'b0, n, re, we, wat);

      // Requests and address load during ACCESS are ignored
      sb.push_back('{1'b0, 8'h40, 8'h11});
      issue(8'h40, 1'b1, 1'b1, 1'b0, 8'h00);
      wait_done(1'b1, n, re, we, wat);
      chk("ign_latency", n, WS + 2);
      chk("ign_mar", mem_addr, 8'h40);
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (busy) seen++;
      end
      chk("ign_no_restart", seen, 0);
      chk("ign_ready_held", bus_ready, 1);

      // Reset mid-write aborts without a strobe
      issue(8'h50, 1'b1, 1'b0, 1'b1, 8'hEE);
      reset_cycle = 1'b1;
      @(negedge clk);
      reset_cycle = 1'b0;
      chk("rmid_we", mem_we, 0);
      chk("rmid_busy", busy, 0);
      chk("rmid_ready", bus_ready, 0);
      chk("rmid_mem_addr", mem_addr, 0);
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (mem_we) seen++;
      end
      chk("rmid_no_we_after", seen, 0);
      chk("rmid_ram_untouched", ram[8'h50], 8'h00);
      chk("sb_drained", sb.size(), 0);

      // Zero wait states: back-to-back reads issued whenever ready
      for (int i = 1; i <= 3; i++) begin
         zq.push_back('{1'b0, 8'(i), 8'hA0 + 8'(i)});
         z_addr_in   = 8'(i);
         z_addr_load = 1'b1;
         z_rd_req    = 1'b1;
         @(posedge clk);
         @(negedge clk);
         z_addr_load = 1'b0;
         z_rd_req    = 1'b0;
         chk("z_ready_low", z_bus_ready, 0);
         chk("z_re", z_mem_re, 1);
         chk("z_mem_addr", z_mem_addr, i);
         @(negedge clk);
         chk("z_ready_high", z_bus_ready, 1);
         t = zq.pop_front();
         chk("z_data", z_data_out, t.data);
         $display("txn RD addr=%02h data=%02h dout=%02h (ws0)", t.addr, t.data, z_data_out);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Memory bus controller between the CPU datapath and the 8-bit program/data RAM. It holds a memory address register (MAR), runs single read or write accesses with a parameterised number of RAM wait states, and returns read data plus a level `bus_ready` flag. `data_out` drives `cpu_ctrl.instruction` and `bus_ready` drives `cpu_ctrl.bus_ready`. The flag's level semantics let the control FSM spin in its RAM-wait state until data is valid.

## Interface
- `ADDR_W`, default 8: width of MAR and of the RAM address.
- `WAIT_STATES`, default 2: extra RAM cycles per access; legal range 0..15.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset_cycle`  in  1  synchronous, active-high reset.
- `addr_in`  in  ADDR_W  address from PC/SP/register bus.
- `addr_load`  in  1  load `addr_in` into MAR.
- `rd_req`  in  1  start read at MAR.
- `wr_req`  in  1  start write of `wr_data` at MAR.
- `wr_data`  in  8  write data.
- `data_out`  out  8  last read data (registered).
- `bus_ready`  out  1  last accepted access complete; level.
- `busy`  out  1  access in progress.
- `mem_addr`  out  ADDR_W  RAM address; always equals MAR.
- `mem_rdata`  in  8  RAM read data; valid by the end of the final access cycle.
- `mem_wdata`  out  8  RAM write data; registered copy of `wr_data`.
- `mem_re`  out  1  RAM read enable.
- `mem_we`  out  1  RAM write strobe.

## Operation
- **States.**
  - IDLE: nothing pending.
  - ACCESS: counter `wcnt` (4 bits) counts down from WAIT_STATES; latched `is_wr` selects read or write.
  - DONE: access complete.
- **Acceptance.** A request is accepted only in IDLE or DONE. In ACCESS, `rd_req`, `wr_req` and `addr_load` are ignored, not queued. MAR is unchanged.
- **Priority.** `wr_req` and `rd_req` high together: the write wins and the read is dropped.
- **Same-cycle address load.** `addr_load` with a request in the same cycle: MAR and the access both use `addr_in` (bypass).
  - `mem_addr` shows the new value from the next cycle.
  - The RAM sees the correct address for the whole access.
- **On acceptance.** State goes to ACCESS, `wcnt` is set to WAIT_STATES, and `bus_ready` is cleared. For a write, `wr_data` is latched into `mem_wdata`.
- **ACCESS.**
  - `busy`=1 throughout.
  - Read: `mem_re`=1 for all ACCESS cycles.
  - Write: `mem_we`=1 only in the cycle where `wcnt`==0.
  - At each edge with `wcnt`!=0: decrement `wcnt`.
  - At the edge with `wcnt`==0: a read captures `mem_rdata` into `data_out`; state goes to DONE and `bus_ready` is set.
- **DONE.** `bus_ready` stays 1 until the edge that accepts a new request or an `addr_load`. `data_out` holds until the next read completes; writes never modify it.
- **Addressing.** MAR is ADDR_W bits. Address arithmetic belongs to the PC/SP blocks; this block performs none, so no wrap logic is needed here.

## Timing
- **Reset values** (the edge with `reset_cycle`=1):
  - State IDLE, MAR=0, `wcnt`=0, `is_wr`=0.
  - `data_out`=0, `mem_wdata`=0, `mem_addr`=0.
  - `bus_ready`=0, `busy`=0, `mem_re`=0, `mem_we`=0.
- **Reset mid-access.** Reset has priority over everything. An in-flight write that reset aborts must not strobe `mem_we` in the cycle after reset.
- **Latency.** With the request accepted at edge E0, `bus_ready` is 1 from edge E0+WAIT_STATES+1. ACCESS lasts exactly WAIT_STATES+1 cycles. With WAIT_STATES=0, `bus_ready` is 1 after one cycle.
- **Back-to-back.** A new request in DONE is accepted at the next edge. `bus_ready` falls at that same edge, so throughput is one access per WAIT_STATES+2 cycles.
- **Output sourcing.**
  - `busy`, `mem_re` and `mem_we` decode from registered state only.
  - `bus_ready` and `data_out` are registered.
  - No combinational path from request inputs to any output.

## Test plan
- **Reset.** Assert `reset_cycle` with `rd_req`=1 → all outputs 0 the next cycle; no `mem_re`/`mem_we` pulse.
- **Read, WAIT_STATES=2.**
  - Stimulus: `addr_in`=8'h10, `addr_load`=1 and `rd_req`=1 at E0; RAM[8'h10]=8'hA5.
  - Response: `mem_addr`=8'h10; `mem_re` high 3 cycles; `bus_ready`=1 from E3 with `data_out`=8'hA5, holding until the next request.
- **Write then read-back.**
  - Stimulus: MAR=8'h3F, `wr_data`=8'h5C, `wr_req` at E0.
  - Response: `mem_we` high only in the cycle before E3; `data_out` unchanged; a following read of 8'h3F returns 8'h5C.
- **Collision.** `rd_req`=`wr_req`=1 in IDLE → write performed, `mem_re` never asserted.
- **Ignored inputs during ACCESS.**
  - Stimulus: mid-access, `addr_load` with 8'h77 and `rd_req`.
  - Response: MAR and the access unchanged; completion cycle unchanged; no second access starts afterwards.
- **WAIT_STATES=0.**
  - Stimulus: reads of 8'h01, 8'h02, 8'h03 issued whenever `bus_ready`=1.
  - Response: one read per 2 cycles; `data_out` sequence correct; `bus_ready` pattern 1,0,1,0 after the first.
